// File: rtl/gcm_ctr_block_gen_if.sv
// Handshake bundle between the GCTR counter-block generator and its neighbours:
// message/data inputs from the feeder and the counter/data stream to the AES ladder.
interface gcm_ctr_block_gen_if #(
   parameter int NB_BLK = 128,
   parameter int NB_IV  = 96
);
   logic              i_start;
   logic [NB_IV-1:0]  i_iv;
   logic [NB_BLK-1:0] i_data;
   logic              i_valid;
   logic              i_last;
   logic              o_ready;
   logic [NB_BLK-1:0] o_state;
   logic [NB_BLK-1:0] o_data;
   logic              o_valid;
   logic              o_j0;
   logic              o_last;
   logic              o_busy;
   logic              o_err;

   modport slave (
      input  i_start, i_iv, i_data, i_valid, i_last,
      output o_ready, o_state, o_data, o_valid, o_j0, o_last, o_busy, o_err
   );

   modport master (
      output i_start, i_iv, i_data, i_valid, i_last,
      input  o_ready, o_state, o_data, o_valid, o_j0, o_last, o_busy, o_err
   );
endinterface

// File: rtl/gcm_ctr_block_gen.sv
// GCTR counter-block generator: emits J0 = {IV, 1} with zero data, then pairs
// each accepted input block with inc32 of the previous counter block.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no message; inputs are dropped (sets o_err)
// J0      | one cycle; J0 block is emitted on the next edge
// RUN     | o_ready=1; each accepted block emitted with {IV, CTR}
module gcm_ctr_block_gen #(
   parameter int NB_BYTE = 8,
   parameter int N_BYTES = 16,
   parameter int NB_IV   = 96,
   parameter int NB_CTR  = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   gcm_ctr_block_gen_if.slave bus
);
   localparam int NB_BLK = N_BYTES * NB_BYTE;
   localparam logic [NB_CTR-1:0] CTR_ONE   = NB_CTR'(1);
   localparam logic [NB_CTR-1:0] CTR_TWO   = NB_CTR'(2);
   // Blocks accepted before the one that hits the GCM 2^32-2 limit.
   localparam logic [NB_CTR-1:0] CNT_LIMIT = {{(NB_CTR-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {ST_IDLE, ST_J0, ST_RUN} state_t;

   state_t            state;
   logic [NB_IV-1:0]  iv_q;
   logic [NB_CTR-1:0] ctr;
   logic [NB_CTR-1:0] ctr_nxt;
   logic [NB_CTR-1:0] cnt;
   logic [NB_CTR-1:0] cnt_nxt;
   logic              accept;

   // A restart always wins over a concurrent data beat.
   assign accept = bus.i_valid & (state == ST_RUN) & ~bus.i_start;

   // Next counter and block count; wraps mod 2^32 and leaves the IV field alone.
   always_comb begin
      ctr_nxt = ctr;
      cnt_nxt = cnt;
      if (bus.i_start) begin
         ctr_nxt = CTR_ONE;
         cnt_nxt = '0;
      end else if (state == ST_J0) begin
         ctr_nxt = CTR_TWO;
      end else if (accept) begin
         ctr_nxt = ctr + CTR_ONE;
         cnt_nxt = cnt + CTR_ONE;
      end
   end

   // Counter and block-count registers.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         ctr <= '0;
         cnt <= '0;
      end else begin
         ctr <= ctr_nxt;
         cnt <= cnt_nxt;
      end
   end

   // Message FSM with registered ladder-side outputs.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= ST_IDLE;
         iv_q        <= '0;
         bus.o_ready <= 1'b0;
         bus.o_state <= '0;
         bus.o_data  <= '0;
         bus.o_valid <= 1'b0;
         bus.o_j0    <= 1'b0;
         bus.o_last  <= 1'b0;
         bus.o_busy  <= 1'b0;
         bus.o_err   <= 1'b0;
      end else begin
         bus.o_valid <= 1'b0;
         bus.o_j0    <= 1'b0;
         bus.o_last  <= 1'b0;
         if (bus.i_start) begin
            iv_q        <= bus.i_iv;
            state       <= ST_J0;
            bus.o_ready <= 1'b0;
            bus.o_busy  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.i_valid) bus.o_err <= 1'b1;
               end
               ST_J0: begin
                  bus.o_state <= {iv_q, ctr};
                  bus.o_data  <= '0;
                  bus.o_valid <= 1'b1;
                  bus.o_j0    <= 1'b1;
                  bus.o_ready <= 1'b1;
                  state       <= ST_RUN;
                  if (bus.i_valid) bus.o_err <= 1'b1;
               end
               ST_RUN: begin
                  if (bus.i_valid) begin
                     bus.o_state <= {iv_q, ctr};
                     bus.o_data  <= bus.i_data;
                     bus.o_valid <= 1'b1;
                     bus.o_last  <= bus.i_last;
                     if (cnt == CNT_LIMIT) bus.o_err <= 1'b1;
                     if (bus.i_last) begin
                        state       <= ST_IDLE;
                        bus.o_ready <= 1'b0;
                        bus.o_busy  <= 1'b0;
                     end
                  end
               end
               default: begin
                  state       <= ST_IDLE;
                  bus.o_ready <= 1'b0;
                  bus.o_busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gcm_ctr_block_gen.sv
// Bench for the GCTR counter-block generator: constant vector table, directed
// corner sequences and a randomized run against a message-level reference model.
module tb_gcm_ctr_block_gen;
   logic i_clock;
   logic i_reset;

   gcm_ctr_block_gen_if bus ();

   gcm_ctr_block_gen dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   int n_pass  = 0;
   int n_check = 0;

   // Reference model: message position, next counter value, blocks sent.
   logic [95:0]  m_iv;
   logic [31:0]  m_ctr;
   longint       m_cnt;
   bit           m_in_msg;
   bit           m_j0_due;
   bit           m_err;
   logic [127:0] e_state, e_data;
   bit           e_valid, e_j0, e_last;

   typedef struct {
      bit           start;
      logic [95:0]  iv;
      bit           valid;
      bit           last;
      logic [127:0] data;
      bit           ev;
      bit           ej0;
      bit           el;
      logic [31:0]  ectr;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_check++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      m_iv = '0; m_ctr = '0; m_cnt = 0; m_in_msg = 0; m_j0_due = 0; m_err = 0;
      e_state = '0; e_data = '0; e_valid = 0; e_j0 = 0; e_last = 0;
   endfunction

   function automatic void model_step(input bit st, input logic [95:0] iv, input bit v,
                                      input bit l, input logic [127:0] d);
      e_valid = 0; e_j0 = 0; e_last = 0;
      if (st) begin
         m_iv = iv; m_ctr = 32'd1; m_cnt = 0; m_in_msg = 1; m_j0_due = 1;
      end else if (m_j0_due) begin
         e_state = {m_iv, 32'd1}; e_data = '0; e_valid = 1; e_j0 = 1;
         m_ctr = 32'd2; m_j0_due = 0;
         if (v) m_err = 1;
      end else if (m_in_msg) begin
         if (v) begin
            e_state = {m_iv, m_ctr}; e_data = d; e_valid = 1; e_last = l;
            if (m_cnt == 64'd4294967294) m_err = 1;
            m_ctr = m_ctr + 32'd1;
            m_cnt = m_cnt + 1;
            if (l) m_in_msg = 0;
         end
      end else if (v) begin
         m_err = 1;
      end
   endfunction

   task automatic check_all();
      chk("o_valid", 128'(bus.o_valid), 128'(e_valid));
      chk("o_j0",    128'(bus.o_j0),    128'(e_j0));
      chk("o_last",  128'(bus.o_last),  128'(e_last));
      chk("o_busy",  128'(bus.o_busy),  128'(m_in_msg));
      chk("o_ready", 128'(bus.o_ready), 128'(m_in_msg & ~m_j0_due));
      chk("o_err",   128'(bus.o_err),   128'(m_err));
      chk("o_state", bus.o_state, e_state);
      chk("o_data",  bus.o_data,  e_data);
   endtask

   task automatic drive(input bit st, input logic [95:0] iv, input bit v,
                        input bit l, input logic [127:0] d);
      @(negedge i_clock);
      bus.i_start = st; bus.i_iv = iv; bus.i_valid = v; bus.i_last = l; bus.i_data = d;
      model_step(st, iv, v, l, d);
   endtask

   task automatic step(input bit st, input logic [95:0] iv, input bit v,
                       input bit l, input logic [127:0] d);
      drive(st, iv, v, l, d);
      @(posedge i_clock);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge i_clock);
      bus.i_start = 0; bus.i_valid = 0; bus.i_last = 0;
      i_reset = 1'b0;
      model_reset();
      #2;
      check_all();
      @(negedge i_clock);
      i_reset = 1'b1;
   endtask

   function automatic void add_vec(input bit st, input logic [95:0] iv, input bit v, input bit l,
                                   input logic [127:0] d, input bit ev, input bit ej0,
                                   input bit el, input logic [31:0] ectr);
      vec_t t;
      t.start = st; t.iv = iv; t.valid = v; t.last = l; t.data = d;
      t.ev = ev; t.ej0 = ej0; t.el = el; t.ectr = ectr;
      vecs.push_back(t);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [95:0]  iv_a, iv_b, iv_ones;
      logic [127:0] d;
      iv_a    = 96'hCAFEBABEFACEDBADDECAF888;
      iv_b    = 96'h0123456789ABCDEF00112233;
      iv_ones = '1;
      i_reset = 1'b0;
      bus.i_start = 0; bus.i_iv = '0; bus.i_data = '0; bus.i_valid = 0; bus.i_last = 0;
      model_reset();
      repeat (2) @(negedge i_clock);
      check_all();
      i_reset = 1'b1;

      // Basic 3-block message, then gapped message.
      add_vec(1, iv_a, 0, 0, '0,              0, 0, 0, 32'h0);
      add_vec(0, '0,   0, 0, '0,              1, 1, 0, 32'h1);
      add_vec(0, '0,   1, 0, 128'h1111,       1, 0, 0, 32'h2);
      add_vec(0, '0,   1, 0, 128'h2222,       1, 0, 0, 32'h3);
      add_vec(0, '0,   1, 1, 128'h3333,       1, 0, 1, 32'h4);
      add_vec(0, '0,   0, 0, '0,              0, 0, 0, 32'h4);
      add_vec(1, iv_b, 0, 0, '0,              0, 0, 0, 32'h4);
      add_vec(0, '0,   0, 0, '0,              1, 1, 0, 32'h1);
      add_vec(0, '0,   1, 0, 128'hA5A5,       1, 0, 0, 32'h2);
      add_vec(0, '0,   0, 0, '0,              0, 0, 0, 32'h2);
      add_vec(0, '0,   0, 0, '0,              0, 0, 0, 32'h2);
      add_vec(0, '0,   1, 1, 128'h5A5A,       1, 0, 1, 32'h3);
      foreach (vecs[i]) begin
         step(vecs[i].start, vecs[i].iv, vecs[i].valid, vecs[i].last, vecs[i].data);
         chk($sformatf("tbl%0d_valid", i), 128'(bus.o_valid), 128'(vecs[i].ev));
         chk($sformatf("tbl%0d_j0", i),    128'(bus.o_j0),    128'(vecs[i].ej0));
         chk($sformatf("tbl%0d_last", i),  128'(bus.o_last),  128'(vecs[i].el));
         chk($sformatf("tbl%0d_ctr", i),   128'(bus.o_state[31:0]), 128'(vecs[i].ectr));
      end
      chk("basic_busy_after", 128'(bus.o_busy), 128'(0));
      chk("basic_err_after",  128'(bus.o_err),  128'(0));

      // Counter wrap and exhaustion limit, IV all ones.
      step(1, iv_ones, 0, 0, '0);
      step(0, '0, 0, 0, '0);
      drive(0, '0, 0, 0, '0);
      force dut.ctr_nxt = 32'hFFFF_FFFF;
      force dut.cnt_nxt = 32'hFFFF_FFFE;
      @(posedge i_clock);
      #1;
      release dut.ctr_nxt;
      release dut.cnt_nxt;
      m_ctr = 32'hFFFF_FFFF;
      m_cnt = 64'd4294967294;
      check_all();
      chk("wrap_err_before", 128'(bus.o_err), 128'(0));
      step(0, '0, 1, 0, 128'hBEEF);
      chk("wrap_ctr_ff", bus.o_state, {iv_ones, 32'hFFFF_FFFF});
      chk("exhaust_err", 128'(bus.o_err), 128'(1));
      step(0, '0, 1, 1, 128'hF00D);
      chk("wrap_ctr_00", bus.o_state, {iv_ones, 32'h0000_0000});

      // Restart with concurrent i_valid mid-RUN.
      do_reset();
      step(1, iv_a, 0, 0, '0);
      step(0, '0, 0, 0, '0);
      step(0, '0, 1, 0, 128'h7777);
      step(1, '0, 1, 0, 128'hDEAD);
      chk("restart_no_old", 128'(bus.o_valid), 128'(0));
      step(0, '0, 0, 0, '0);
      chk("restart_j0", bus.o_state, {96'h0, 32'h1});
      chk("restart_j0_flag", 128'(bus.o_j0), 128'(1));
      chk("restart_err", 128'(bus.o_err), 128'(0));
      step(0, '0, 1, 1, 128'h9999);
      chk("restart_ctr2", bus.o_state, {96'h0, 32'h2});

      // Dropped input in IDLE.
      do_reset();
      step(0, '0, 1, 0, 128'h1234);
      chk("idle_drop_valid", 128'(bus.o_valid), 128'(0));
      chk("idle_drop_err", 128'(bus.o_err), 128'(1));

      // Dropped input in the J0 cycle; error stays sticky.
      do_reset();
      step(1, iv_b, 0, 0, '0);
      step(0, '0, 1, 0, 128'h4321);
      chk("j0_drop_isj0", 128'(bus.o_j0), 128'(1));
      chk("j0_drop_data", bus.o_data, 128'h0);
      step(0, '0, 1, 1, 128'h5555);
      chk("j0_drop_ctr2", bus.o_state, {iv_b, 32'h2});
      step(0, '0, 0, 0, '0);
      chk("err_sticky", 128'(bus.o_err), 128'(1));

      // Asynchronous reset mid-RUN.
      do_reset();
      step(1, iv_a, 0, 0, '0);
      step(0, '0, 0, 0, '0);
      step(0, '0, 1, 0, 128'hCCCC);
      #2;
      i_reset = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_state_zero", bus.o_state, 128'h0);
      @(negedge i_clock);
      i_reset = 1'b1;
      step(0, '0, 1, 0, 128'hDDDD);
      chk("post_reset_ignored", 128'(bus.o_valid), 128'(0));

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         bit st, v, l;
         st = ($urandom_range(0, 19) == 0);
         v  = ($urandom_range(0, 9) < 6);
         l  = ($urandom_range(0, 5) == 0);
         d  = {$urandom(), $urandom(), $urandom(), $urandom()};
         step(st, {$urandom(), $urandom(), $urandom()}, v, l, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end
endmodule

// File: doc/gcm_ctr_block_gen.md
Name: gcm_ctr_block_gen

Overview:
- Upstream feeder for the AES round ladder with output data XOR in the AES-GCM GCTR datapath.
- Builds counter blocks J0, inc32(J0), inc32²(J0), ... from a 96-bit IV.
- Pairs each counter block with one plaintext/ciphertext block and presents state/data/valid to the ladder, one block per clock.
- Emits J0 (zero data, flagged) first, so the ladder output for J0 is E(K,J0) for tag generation.

Parameters:
- NB_BYTE, 8, bits per byte.
- N_BYTES, 16, bytes per block; block width NB_BLK = N_BYTES*NB_BYTE.
- NB_IV, 96, IV width; must equal NB_BLK-NB_CTR.
- NB_CTR, 32, width of the incrementing counter field (inc32).
- Configurations other than 8/16/96/32 are unsupported.

Ports:
- i_clock  in  1  clock; all flops rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse: load i_iv and begin a message.
- i_iv  in  NB_IV  IV, sampled only when i_start=1.
- i_data  in  NB_BLK  input block, sampled when i_valid & o_ready.
- i_valid  in  1  i_data qualifier.
- i_last  in  1  marks the final block of the message; sampled with i_valid.
- o_ready  out  1  block accepts i_data this cycle.
- o_state  out  NB_BLK  counter block to the ladder state input.
- o_data  out  NB_BLK  data block to the ladder data input; zero for J0.
- o_valid  out  1  o_state/o_data qualifier.
- o_j0  out  1  current output is the J0 block.
- o_last  out  1  current output is the message's final block.
- o_busy  out  1  message in progress (state != IDLE).
- o_err  out  1  sticky error: dropped input or counter exhaustion.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - FSM goes to IDLE.
  - o_valid, o_j0, o_last, o_busy, o_err, o_ready = 0.
  - o_state, o_data, IV register, counter and block count = 0.
- All outputs are registered. Latency from an accepted input to its o_valid is 1 cycle. No backpressure from downstream: the ladder always accepts.
- Counter block format: {IV[95:0], CTR[31:0]}, IV in the MSBs. J0 = {IV, 32'h00000001}.
- FSM states IDLE, J0, RUN.
- IDLE:
  - o_ready=0.
  - i_start=1 -> latch IV, CTR<=1, block count<=0, go to J0.
  - i_valid while in IDLE is dropped and sets o_err.
- J0 (exactly 1 cycle):
  - o_ready=0.
  - Next edge registers o_state=J0, o_data=0, o_valid=1, o_j0=1, o_last=0.
  - CTR<=2, go to RUN.
  - i_valid in this cycle is dropped and sets o_err.
- RUN:
  - o_ready=1.
  - On i_valid: o_state={IV,CTR}, o_data=i_data, o_valid=1, o_j0=0, o_last=i_last.
  - Also on i_valid: CTR <= CTR+1 mod 2^32 (wraps FFFFFFFF->00000000, IV field untouched); block count +1.
  - i_valid & i_last -> IDLE in the same edge.
  - No i_valid -> o_valid=0, state held.
- Counter exhaustion: accepting a block when block count = 2^32-2 (GCM limit) still emits the block, sets o_err, and wraps normally.
- i_start in any state (including RUN, or simultaneous with i_valid):
  - Restart wins: new IV latched, go to J0.
  - The concurrent i_valid is dropped without setting o_err.
  - No partial block of the old message is emitted after the start edge.
- o_err clears only on reset.
- o_busy = 1 in J0 and RUN.
- Data and state pass unmodified; no XOR is performed here.

Test Plan:
- Reset then start, IV=96'hCAFEBABEFACEDBADDECAF888, 3 blocks back-to-back, last on 3rd:
  - Outputs, in order: J0 ({IV,00000001}, data 0, o_j0=1); {IV,00000002}; {IV,00000003}; {IV,00000004} with o_last=1.
  - Then o_busy=0, o_err=0.
- Gapped input (i_valid 1,0,0,1) in RUN -> o_valid mirrors with 1-cycle latency; CTR increments only on accepted blocks.
- i_valid asserted in IDLE, and in the J0 cycle -> no o_valid for it; o_err=1 and stays 1 until reset.
- Force CTR=FFFFFFFF (IV all ones), send 2 blocks -> o_state low words FFFFFFFF then 00000000; upper 96 bits unchanged.
- i_start with i_valid high mid-RUN, new IV=0 -> next output is J0={0,00000001}; old block not emitted; o_err unchanged.
- Assert i_reset low asynchronously mid-RUN -> all outputs 0 immediately; after release, i_valid is ignored until a new i_start.
